// File: rtl/tnoc_axi_types_pkg.sv
// Shared tnoc AXI types: state encoding for the read-channel arbiter FSM.
package tnoc_axi_types_pkg;

    typedef enum logic {
        TNOC_AXI_ARB_IDLE  = 1'b0,
        TNOC_AXI_ARB_GRANT = 1'b1
    } tnoc_axi_arb_state_e;

endpackage

// File: rtl/tnoc_axi_read_order_fifo.sv
// Synchronous FIFO holding requester indices in AR-issue order so R bursts can be
// routed back to their issuer. DEPTH must be a power of 2 (>= 2).
module tnoc_axi_read_order_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_FULL);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/tnoc_axi_read_channel_arbiter.sv
// Round-robin AR arbiter sharing one AXI read master among REQUESTERS sources; R bursts
// return in issue order via a grant-order FIFO. Optional: TNOC_AXI_READ_ARB_OUTSTANDING_LIMIT_EN.
module tnoc_axi_read_channel_arbiter
    import tnoc_axi_types_pkg::*;
#(
    parameter int REQUESTERS      = 4,
    parameter int ID_WIDTH        = 8,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 256,
    parameter int ORDER_DEPTH     = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REQUESTERS-1:0]            s_arvalid,
    output logic [REQUESTERS-1:0]            s_arready,
    input  logic [REQUESTERS*ID_WIDTH-1:0]   s_arid,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] s_araddr,
    input  logic [REQUESTERS*8-1:0]          s_arlen,
    input  logic [REQUESTERS*3-1:0]          s_arsize,
    input  logic [REQUESTERS*2-1:0]          s_arburst,
    output logic [REQUESTERS-1:0]            s_rvalid,
    input  logic [REQUESTERS-1:0]            s_rready,
    output logic [ID_WIDTH-1:0]              s_rid,
    output logic [DATA_WIDTH-1:0]            s_rdata,
    output logic [1:0]                       s_rresp,
    output logic                             s_rlast,
    output logic                             m_arvalid,
    input  logic                             m_arready,
    output logic [ID_WIDTH-1:0]              m_arid,
    output logic [ADDR_WIDTH-1:0]            m_araddr,
    output logic [7:0]                       m_arlen,
    output logic [2:0]                       m_arsize,
    output logic [1:0]                       m_arburst,
    input  logic                             m_rvalid,
    output logic                             m_rready,
    input  logic [ID_WIDTH-1:0]              m_rid,
    input  logic [DATA_WIDTH-1:0]            m_rdata,
    input  logic [1:0]                       m_rresp,
    input  logic                             m_rlast,
    output logic                             o_protocol_error
);
    localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REQUESTERS - 1);

    tnoc_axi_arb_state_e r_state;
    tnoc_axi_arb_state_e w_state_next;
    logic [IDX_W-1:0]      r_grant;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      w_pick;
    logic                  w_pick_valid;
    logic [REQUESTERS-1:0] w_eligible;
    logic [REQUESTERS-1:0] w_excluded;
    logic                  w_ar_hs;
    logic                  w_r_pop;
    logic [IDX_W-1:0]      w_head;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic [$clog2(ORDER_DEPTH):0] w_unused_fifo_count;
    logic                  r_protocol_error;

    assign w_eligible = s_arvalid & ~w_excluded;
    assign w_ar_hs    = (r_state == TNOC_AXI_ARB_GRANT) & m_arready;

    // First eligible requester at or after the RR pointer; walked backwards so the
    // nearest one wins.
    always_comb begin
        int idx;
        w_pick       = r_rr_ptr;
        w_pick_valid = 1'b0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % REQUESTERS;
            if (w_eligible[idx]) begin
                w_pick       = IDX_W'(idx);
                w_pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= TNOC_AXI_ARB_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            TNOC_AXI_ARB_IDLE:  if (w_pick_valid && !w_fifo_full) w_state_next = TNOC_AXI_ARB_GRANT;
            TNOC_AXI_ARB_GRANT: if (m_arready) w_state_next = TNOC_AXI_ARB_IDLE;
            default:            w_state_next = TNOC_AXI_ARB_IDLE;
        endcase
    end

    always_comb begin
        m_arvalid = 1'b0;
        s_arready = '0;
        if (r_state == TNOC_AXI_ARB_GRANT) begin
            m_arvalid          = 1'b1;
            s_arready[r_grant] = m_arready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (r_state == TNOC_AXI_ARB_IDLE && w_state_next == TNOC_AXI_ARB_GRANT)
                r_grant <= w_pick;
            if (w_ar_hs)
                r_rr_ptr <= (r_grant == IDX_LAST) ? '0 : r_grant + IDX_ONE;
        end
    end

    assign m_arid    = s_arid   [r_grant*ID_WIDTH   +: ID_WIDTH];
    assign m_araddr  = s_araddr [r_grant*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_arlen   = s_arlen  [r_grant*8 +: 8];
    assign m_arsize  = s_arsize [r_grant*3 +: 3];
    assign m_arburst = s_arburst[r_grant*2 +: 2];

    tnoc_axi_read_order_fifo #(
        .DEPTH (ORDER_DEPTH),
        .WIDTH (IDX_W)
    ) u_order_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_ar_hs),
        .i_push_data (r_grant),
        .i_pop       (w_r_pop),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full),
        .o_count     (w_unused_fifo_count)
    );

    // R path is pure routing: the FIFO head names the only requester allowed to see beats.
    always_comb begin
        s_rvalid         = '0;
        s_rvalid[w_head] = m_rvalid & ~w_fifo_empty;
        m_rready         = ~w_fifo_empty & s_rready[w_head];
    end

    assign w_r_pop = m_rvalid & m_rready & m_rlast;
    assign s_rid   = m_rid;
    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;
    assign s_rlast = m_rlast;

    always_ff @(posedge clk) begin
        if (rst)                          r_protocol_error <= 1'b0;
        else if (m_rvalid && w_fifo_empty) r_protocol_error <= 1'b1;
    end
    assign o_protocol_error = r_protocol_error;

`ifdef TNOC_AXI_READ_ARB_OUTSTANDING_LIMIT_EN
    localparam int OCNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OCNT_W-1:0] OCNT_ONE = OCNT_W'(1);
    localparam logic [OCNT_W-1:0] OCNT_MAX = OCNT_W'(MAX_OUTSTANDING);

    logic [REQUESTERS-1:0][OCNT_W-1:0] r_ocnt;

    for (genvar g = 0; g < REQUESTERS; g++) begin : g_ocnt
        logic w_inc;
        logic w_dec;
        assign w_inc = w_ar_hs & (r_grant == IDX_W'(g));
        assign w_dec = w_r_pop & (w_head == IDX_W'(g));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ocnt[g] <= '0;
            end else begin
                case ({w_inc, w_dec})
                    2'b10:   r_ocnt[g] <= r_ocnt[g] + OCNT_ONE;
                    2'b01:   r_ocnt[g] <= r_ocnt[g] - OCNT_ONE;
                    default: r_ocnt[g] <= r_ocnt[g];
                endcase
            end
        end
        assign w_excluded[g] = (r_ocnt[g] == OCNT_MAX);
    end
`else
    localparam int unused_max_outstanding = MAX_OUTSTANDING;
    assign w_excluded = '0;
`endif

endmodule

// File: tb/tb_tnoc_axi_read_channel_arbiter.sv
// Self-checking bench: directed table + hand sequences + random traffic against a
// queue-based reference model. Honours TNOC_AXI_READ_ARB_OUTSTANDING_LIMIT_EN.
module tb_tnoc_axi_read_channel_arbiter;
    localparam int R     = 4;
    localparam int IDW   = 8;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;
`ifdef TNOC_AXI_READ_ARB_OUTSTANDING_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [R-1:0]      arv = '0;
    logic [AW-1:0]     req_addr  [R];
    logic [7:0]        req_len   [R];
    logic [2:0]        req_size  [R];
    logic [1:0]        req_burst [R];
    logic [R*IDW-1:0]  s_arid;
    logic [R*AW-1:0]   s_araddr;
    logic [R*8-1:0]    s_arlen;
    logic [R*3-1:0]    s_arsize;
    logic [R*2-1:0]    s_arburst;
    logic [R-1:0]      s_arready, s_rvalid;
    logic [R-1:0]      s_rready = '0;
    logic [IDW-1:0]    s_rid;
    logic [DW-1:0]     s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic              m_arvalid;
    logic              m_arready = 1'b0;
    logic [IDW-1:0]    m_arid;
    logic [AW-1:0]     m_araddr;
    logic [7:0]        m_arlen;
    logic [2:0]        m_arsize;
    logic [1:0]        m_arburst;
    logic              m_rvalid = 1'b0;
    logic              m_rready;
    logic [IDW-1:0]    m_rid = '0;
    logic [DW-1:0]     m_rdata = '0;
    logic [1:0]        m_rresp = '0;
    logic              m_rlast = 1'b0;
    logic              o_protocol_error;

    for (genvar g = 0; g < R; g++) begin : g_pack
        assign s_arid   [g*IDW +: IDW] = IDW'(16 + g);
        assign s_araddr [g*AW  +: AW]  = req_addr[g];
        assign s_arlen  [g*8   +: 8]   = req_len[g];
        assign s_arsize [g*3   +: 3]   = req_size[g];
        assign s_arburst[g*2   +: 2]   = req_burst[g];
    end

    tnoc_axi_read_channel_arbiter #(
        .REQUESTERS(R), .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .ORDER_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_arvalid(arv), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .o_protocol_error(o_protocol_error)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: pending grant (-1 = none), issue-order queue of bursts, RR start.
    int mdl_pend = -1;
    int mdl_q[$];
    int mdl_len[$];
    int mdl_rr   = 0;
    bit mdl_err  = 1'b0;
    int mdl_cnt[R];
    int mdl_beat = 0;
    int hs_idx   = -1;
    bit r_hs     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    function automatic bit mdl_excl(input int i);
        return LIMIT_EN && (mdl_cnt[i] >= MAXO);
    endfunction

    task automatic model_check();
        logic [R-1:0] e_arready;
        logic [R-1:0] e_rvalid;
        logic         e_rready;
        e_arready = '0;
        e_rvalid  = '0;
        e_rready  = 1'b0;
        if (mdl_pend >= 0) e_arready[mdl_pend] = m_arready;
        if (mdl_q.size() > 0) begin
            e_rvalid[mdl_q[0]] = m_rvalid;
            e_rready           = s_rready[mdl_q[0]];
        end
        chk("m_arvalid", m_arvalid, mdl_pend >= 0);
        chk("s_arready", s_arready, e_arready);
        if (mdl_pend >= 0) begin
            chk("m_arid",    m_arid,    IDW'(16 + mdl_pend));
            chk("m_araddr",  m_araddr,  req_addr[mdl_pend]);
            chk("m_arlen",   m_arlen,   req_len[mdl_pend]);
            chk("m_arsize",  m_arsize,  req_size[mdl_pend]);
            chk("m_arburst", m_arburst, req_burst[mdl_pend]);
        end
        chk("s_rvalid", s_rvalid, e_rvalid);
        chk("m_rready", m_rready, e_rready);
        chk("protocol_error", o_protocol_error, mdl_err);
        chk("r_broadcast", {s_rid, s_rresp, s_rlast}, {m_rid, m_rresp, m_rlast});
        chk("r_data", s_rdata, m_rdata);
    endtask

    task automatic model_update();
        bit full;
        bit found;
        bit rhs;
        hs_idx = -1;
        r_hs   = 1'b0;
        if (rst) begin
            mdl_pend = -1;
            mdl_q.delete();
            mdl_len.delete();
            mdl_rr   = 0;
            mdl_err  = 1'b0;
            mdl_beat = 0;
            for (int i = 0; i < R; i++) mdl_cnt[i] = 0;
            return;
        end
        full = (mdl_q.size() >= DEPTH);
        rhs  = m_rvalid && (mdl_q.size() > 0) && s_rready[mdl_q[0]];
        if (m_rvalid && mdl_q.size() == 0) mdl_err = 1'b1;
        if (mdl_pend >= 0) begin
            if (m_arready) begin
                hs_idx = mdl_pend;
                mdl_q.push_back(mdl_pend);
                mdl_len.push_back(int'(req_len[mdl_pend]));
                mdl_cnt[mdl_pend]++;
                mdl_rr   = (mdl_pend + 1) % R;
                mdl_pend = -1;
            end
        end else if (!full) begin
            found = 1'b0;
            for (int k = 0; k < R; k++) begin
                if (!found && arv[(mdl_rr + k) % R] && !mdl_excl((mdl_rr + k) % R)) begin
                    mdl_pend = (mdl_rr + k) % R;
                    found    = 1'b1;
                end
            end
        end
        if (rhs) begin
            r_hs = 1'b1;
            if (m_rlast) begin
                mdl_cnt[mdl_q[0]]--;
                void'(mdl_q.pop_front());
                void'(mdl_len.pop_front());
                mdl_beat = 0;
            end else begin
                mdl_beat++;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        sample();
        adv();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        arv      = '0;
        m_rvalid = 1'b0;
        adv();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int exp_req);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            sample();
            if (m_arvalid === 1'b1) begin
                got = 1'b1;
                chk($sformatf("grant_id_req%0d", exp_req), m_arid, IDW'(16 + exp_req));
            end
            adv();
            if (hs_idx >= 0) arv[hs_idx] = 1'b0;
        end
        if (!got) fail_now($sformatf("grant_wait_req%0d", exp_req));
    endtask

    task automatic drive_random();
        for (int i = 0; i < R; i++) begin
            if (hs_idx == i) arv[i] = 1'b0;
            if (!arv[i] && $urandom_range(0, 3) == 0) begin
                arv[i]       = 1'b1;
                req_addr[i]  = $urandom;
                req_len[i]   = 8'($urandom_range(0, 3));
                req_size[i]  = 3'($urandom);
                req_burst[i] = 2'($urandom);
            end
        end
        m_arready = 1'($urandom);
        s_rready  = R'($urandom);
        if (m_rvalid && !r_hs) begin
            m_rvalid = 1'b1;
        end else if (mdl_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            m_rvalid = 1'b1;
            m_rlast  = (mdl_beat == mdl_len[0]);
            m_rdata  = $urandom;
            m_rid    = IDW'($urandom);
            m_rresp  = 2'($urandom);
        end else begin
            m_rvalid = 1'b0;
        end
    endtask

    typedef struct {
        logic [R-1:0]   arv;
        logic           rv;
        logic           exp_arvalid;
        logic [IDW-1:0] exp_arid;
        logic [R-1:0]   exp_rvalid;
    } vec_t;

    vec_t tbl [16];

    initial begin
        // All four requesters contend with single-beat bursts; DEPTH=4 blocks the 5th
        // grant until the first rlast, then R returns in issue order.
        tbl[0]  = '{4'hF, 1'b0, 1'b0, 8'h00, 4'h0};
        tbl[1]  = '{4'hF, 1'b0, 1'b1, 8'h10, 4'h0};
        tbl[2]  = '{4'hF, 1'b0, 1'b0, 8'h00, 4'h0};
        tbl[3]  = '{4'hF, 1'b0, 1'b1, 8'h11, 4'h0};
        tbl[4]  = '{4'hF, 1'b0, 1'b0, 8'h00, 4'h0};
        tbl[5]  = '{4'hF, 1'b0, 1'b1, 8'h12, 4'h0};
        tbl[6]  = '{4'hF, 1'b0, 1'b0, 8'h00, 4'h0};
        tbl[7]  = '{4'hF, 1'b0, 1'b1, 8'h13, 4'h0};
        tbl[8]  = '{4'hF, 1'b0, 1'b0, 8'h00, 4'h0};
        tbl[9]  = '{4'hF, 1'b0, 1'b0, 8'h00, 4'h0};
        tbl[10] = '{4'hF, 1'b1, 1'b0, 8'h00, 4'h1};
        tbl[11] = '{4'hF, 1'b1, 1'b0, 8'h00, 4'h2};
        tbl[12] = '{4'hF, 1'b1, 1'b1, 8'h10, 4'h4};
        tbl[13] = '{4'h0, 1'b1, 1'b0, 8'h00, 4'h8};
        tbl[14] = '{4'h0, 1'b1, 1'b0, 8'h00, 4'h1};
        tbl[15] = '{4'h0, 1'b0, 1'b0, 8'h00, 4'h0};

        for (int i = 0; i < R; i++) begin
            req_addr[i]  = '0;
            req_len[i]   = '0;
            req_size[i]  = 3'd5;
            req_burst[i] = 2'd1;
        end

        // Reset state
        m_arready = 1'b1;
        s_rready  = '1;
        do_reset();
        sample();
        chk("rst_m_arvalid", m_arvalid, 1'b0);
        chk("rst_s_arready", s_arready, '0);
        chk("rst_s_rvalid", s_rvalid, '0);
        chk("rst_m_rready", m_rready, 1'b0);
        chk("rst_protocol_error", o_protocol_error, 1'b0);
        adv();

        // Single requester 2, 4-beat burst
        do_reset();
        arv = 4'b0100;
        req_addr[2] = 32'h1000;
        req_len[2]  = 8'd3;
        sample();
        chk("t1_arvalid_same_cycle", m_arvalid, 1'b0);
        adv();
        sample();
        chk("t1_arvalid_next_cycle", m_arvalid, 1'b1);
        chk("t1_araddr", m_araddr, 32'h1000);
        chk("t1_arlen", m_arlen, 8'd3);
        adv();
        arv = '0;
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1;
            m_rlast  = (b == 3);
            m_rdata  = DW'(32'hA000 + b);
            sample();
            chk($sformatf("t1_rvalid_beat%0d", b), s_rvalid, 4'b0100);
            adv();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        sample();
        chk("t1_fifo_empty", m_rready, 1'b0);
        adv();

        // Table: round-robin order, depth limit, in-order routing
        do_reset();
        m_arready = 1'b1;
        s_rready  = '1;
        m_rlast   = 1'b1;
        for (int i = 0; i < R; i++) req_len[i] = '0;
        for (int v = 0; v < 16; v++) begin
            arv      = tbl[v].arv;
            m_rvalid = tbl[v].rv;
            sample();
            chk($sformatf("tbl%0d_arvalid", v), m_arvalid, tbl[v].exp_arvalid);
            if (tbl[v].exp_arvalid) chk($sformatf("tbl%0d_arid", v), m_arid, tbl[v].exp_arid);
            chk($sformatf("tbl%0d_rvalid", v), s_rvalid, tbl[v].exp_rvalid);
            adv();
        end
        m_rvalid = 1'b0;

        // AR stall: grant and fields held while m_arready is low
        do_reset();
        m_arready   = 1'b0;
        arv         = 4'b0011;
        req_addr[0] = 32'hCAFE_0000;
        req_len[0]  = 8'd7;
        step();
        for (int c = 0; c < 5; c++) begin
            sample();
            chk("stall_arvalid", m_arvalid, 1'b1);
            chk("stall_arid", m_arid, 8'h10);
            chk("stall_araddr", m_araddr, 32'hCAFE_0000);
            chk("stall_s_arready", s_arready, 4'b0000);
            chk("stall_fifo_empty", m_rready, 1'b0);
            adv();
        end
        m_arready = 1'b1;
        sample();
        chk("stall_release_s_arready", s_arready, 4'b0001);
        adv();
        arv[0] = 1'b0;
        wait_grant(1);

`ifdef TNOC_AXI_READ_ARB_OUTSTANDING_LIMIT_EN
        // Per-requester cap: requester 0 skipped at 2 outstanding, eligible after one rlast
        do_reset();
        m_arready = 1'b1;
        s_rready  = '1;
        for (int i = 0; i < R; i++) req_len[i] = '0;
        arv = 4'b0001;
        wait_grant(0);
        arv[0] = 1'b1;
        wait_grant(0);
        arv = 4'b1000;
        wait_grant(3);
        arv = 4'b0011;
        wait_grant(1);
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        sample();
        chk("limit_rvalid_req0", s_rvalid, 4'b0001);
        adv();
        m_rvalid = 1'b0;
        wait_grant(0);
        arv = '0;
`endif

        // Random traffic with a reset pulse in the middle
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst      = 1'b1;
                m_rvalid = 1'b0;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
            drive_random();
        end

        // Protocol error: R beat with nothing outstanding is sticky until reset
        do_reset();
        s_rready = '1;
        m_rvalid = 1'b1;
        m_rlast  = 1'b1;
        sample();
        chk("perr_m_rready", m_rready, 1'b0);
        chk("perr_s_rvalid", s_rvalid, '0);
        adv();
        m_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("perr_sticky", o_protocol_error, 1'b1);
            adv();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        sample();
        chk("perr_cleared_by_rst", o_protocol_error, 1'b0);
        adv();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
